// File: rtl/io_writeback_arbiter_pkg.sv
// Shared IO constants and the writeback buffer entry type.
// Used by the writeback arbiter, its interface and its sub-modules.
package io_pkg;

  localparam int DATABITWIDTH    = 16;
  localparam int INPUTPORTCOUNT  = 20;
  localparam int PORTADDRWIDTH   = $clog2(INPUTPORTCOUNT);
  localparam int REGADDRBITWIDTH = 4;

  // Response source index ranges inside the InputACK vector
  localparam int IO_CLOCK_RESP_BASE  = 0;
  localparam int IO_TIMER_RESP_BASE  = 4;
  localparam int IO_PORT_RESP_BASE   = 12;
  localparam int IO_SYSTEM_RESPONSES = 12;

  typedef struct packed {
    logic [PORTADDRWIDTH-1:0]   port;
    logic [REGADDRBITWIDTH-1:0] dest;
    logic [DATABITWIDTH-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/io_writeback_arbiter_if.sv
// Writeback bus: per-source response side plus the single register-file side.
// ACK = producer valid, REQ = consumer ready; a transfer happens on a rising edge where both are high and clk_en is high.
interface io_writeback_arbiter_if;
  import io_pkg::*;

  logic [INPUTPORTCOUNT-1:0]                       InputACK;
  logic [INPUTPORTCOUNT-1:0]                       InputREQ;
  logic [INPUTPORTCOUNT-1:0][REGADDRBITWIDTH-1:0]  InputDest;
  logic [INPUTPORTCOUNT-1:0][DATABITWIDTH-1:0]     InputData;
  logic                                            OutputACK;
  logic                                            OutputREQ;
  logic [REGADDRBITWIDTH-1:0]                      OutputDest;
  logic [DATABITWIDTH-1:0]                         OutputData;
  logic [PORTADDRWIDTH-1:0]                        OutputPort;

  modport master (
    input  InputACK, InputDest, InputData, OutputREQ,
    output InputREQ, OutputACK, OutputDest, OutputData, OutputPort
  );

  modport slave (
    output InputACK, InputDest, InputData, OutputREQ,
    input  InputREQ, OutputACK, OutputDest, OutputData, OutputPort
  );

endinterface

// File: rtl/io_writeback_arbiter_picker.sv
// Combinational round-robin picker: first requester at or above i_ptr, wrapping modulo N.
// Produces a one-hot grant, its encoded index and a valid flag.
module rr_priority_picker #(
    parameter int N = 20,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_grant,
    output logic [W-1:0] o_idx,
    output logic         o_valid
);

    int w_j;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (i_req[w_j]) begin
                o_valid = 1'b1;
                o_idx   = w_j[W-1:0];
            end
        end
        if (o_valid) o_grant[o_idx] = 1'b1;
    end

endmodule

// File: rtl/io_writeback_arbiter.sv
// Merges all IO response sources onto the register-file writeback channel.
// Round-robin grant into a 2-entry FIFO whose head register drives the output fields.
module io_writeback_arbiter
    import io_pkg::*;
(
    input  logic                  sys_clk,
    input  logic                  async_rst,
    input  logic                  clk_en,
    io_writeback_arbiter_if.master bus
);

    localparam logic [PORTADDRWIDTH-1:0] LAST_PORT = PORTADDRWIDTH'(INPUTPORTCOUNT - 1);

    logic [PORTADDRWIDTH-1:0]  r_ptr;
    logic [1:0]                r_count;
    wb_entry_t                 r_head;
    wb_entry_t                 r_tail;

    logic [INPUTPORTCOUNT-1:0] w_grant;
    logic [PORTADDRWIDTH-1:0]  w_grant_idx;
    logic                      w_grant_valid;
    logic                      w_can_accept;
    logic                      w_push;
    logic                      w_pop;
    logic [PORTADDRWIDTH-1:0]  w_ptr_next;
    wb_entry_t                 w_new;

    rr_priority_picker #(
        .N (INPUTPORTCOUNT),
        .W (PORTADDRWIDTH)
    ) u_picker (
        .i_req   (bus.InputACK),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_grant_idx),
        .o_valid (w_grant_valid)
    );

    // Held in reset, no source may see ready; a full buffer never bypasses on a same-cycle pop.
    assign w_can_accept  = (r_count != 2'd2) && clk_en && async_rst;
    assign bus.InputREQ  = w_can_accept ? w_grant : '0;
    assign w_push        = w_grant_valid && w_can_accept;

    assign bus.OutputACK = (r_count != 2'd0) && clk_en;
    assign w_pop         = bus.OutputACK && bus.OutputREQ;

    assign w_ptr_next    = (w_grant_idx == LAST_PORT) ? '0 : w_grant_idx + PORTADDRWIDTH'(1);

    always_comb begin
        w_new      = '0;
        w_new.port = w_grant_idx;
        w_new.dest = bus.InputDest[w_grant_idx];
        w_new.data = bus.InputData[w_grant_idx];
    end

    always_ff @(posedge sys_clk or negedge async_rst) begin
        if (!async_rst) begin
            r_ptr   <= '0;
            r_count <= 2'd0;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            if (w_push) r_ptr <= w_ptr_next;
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_head  <= w_new;
                        r_count <= 2'd1;
                    end else begin
                        r_tail  <= w_new;
                        r_count <= 2'd2;
                    end
                end
                2'b01: begin
                    if (r_count == 2'd2) r_head <= r_tail;
                    r_count <= r_count - 2'd1;
                end
                // Push with pop implies exactly one entry: the newcomer replaces the departing head.
                2'b11: r_head <= w_new;
                default: ;
            endcase
        end
    end

    assign bus.OutputDest = r_head.dest;
    assign bus.OutputData = r_head.data;
    assign bus.OutputPort = r_head.port;

endmodule
